// File: rtl/truth_table_checker.sv
// Truth-table checker for a small AND/OR/NOT gate group.
// Accepts one stimulus/response sample, checks it in a single CHECK cycle,
// and accumulates sample/error counts, input-combination coverage and a
// sticky error flag. Once all four (a,b) combinations are covered the block
// parks in DONE and refuses further samples until cleared.
module truth_table_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             y_and,
    input  logic             y_or,
    input  logic             y_not,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov_mask,
    output logic [2:0]       err_vec,
    output logic             error,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured sample; pure datapath, so it carries no reset.
    logic a_p0;
    logic b_p0;
    logic y_and_p0;
    logic y_or_p0;
    logic y_not_p0;

    logic       xfer;
    logic [2:0] mism;
    logic [3:0] cov_upd;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // A clear in the same cycle wins over the handshake and drops the sample.
    assign xfer = in_valid && in_ready && !clear;

    // Mismatch flags ordered {and, or, not}.
    assign mism = {y_and_p0 != (a_p0 & b_p0),
                   y_or_p0  != (a_p0 | b_p0),
                   y_not_p0 != ~a_p0};

    // Coverage including the sample currently being checked.
    assign cov_upd = cov_mask | (4'b0001 << {a_p0, b_p0});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one CHECK cycle per sample, DONE once fully covered.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (xfer) state_nxt = CHECK;
                CHECK:   state_nxt = (cov_upd == 4'b1111) ? DONE : IDLE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode from state.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    done     = 1'b1;
            default: begin
                in_ready = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // Capture the sample on a transfer.
    always_ff @(posedge clk) begin
        if (xfer) begin
            a_p0     <= a;
            b_p0     <= b;
            y_and_p0 <= y_and;
            y_or_p0  <= y_or;
            y_not_p0 <= y_not;
        end
    end

    // Result accumulation on the CHECK exit edge; a clear discards the
    // in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            cov_mask   <= '0;
            err_vec    <= '0;
            error      <= 1'b0;
        end else if (clear) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            cov_mask   <= '0;
            err_vec    <= '0;
            error      <= 1'b0;
        end else if (state == CHECK) begin
            sample_cnt <= sat_inc(sample_cnt);
            cov_mask   <= cov_upd;
            if (|mism) begin
                err_cnt <= sat_inc(err_cnt);
                err_vec <= mism;
                error   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed vectors, expected results queued
// at issue time and compared by an independent monitor when each sample
// completes. A second instance with 2-bit counters covers saturation.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic valid_s = 1'b0;
    logic a = 1'b0, b = 1'b0, y_and = 1'b0, y_or = 1'b0, y_not = 1'b0;

    logic       in_ready, error, done;
    logic [7:0] sample_cnt, err_cnt;
    logic [3:0] cov_mask;
    logic [2:0] err_vec;

    logic       rdy_s, error_s, done_s;
    logic [1:0] sc_s, ec_s;
    logic [3:0] cov_s;
    logic [2:0] ev_s;

    truth_table_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .y_and(y_and), .y_or(y_or),
        .y_not(y_not), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .cov_mask(cov_mask), .err_vec(err_vec), .error(error), .done(done)
    );

    truth_table_checker #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(valid_s),
        .in_ready(rdy_s), .a(a), .b(b), .y_and(y_and), .y_or(y_or),
        .y_not(y_not), .sample_cnt(sc_s), .err_cnt(ec_s),
        .cov_mask(cov_s), .err_vec(ev_s), .error(error_s), .done(done_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sc;
        logic [7:0] ec;
        logic [3:0] cov;
        logic [2:0] ev;
        logic       err;
        logic       dn;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic use_sat = 1'b0;

    // Selected DUT view for the monitor.
    logic       m_valid, m_ready, m_err, m_dn;
    logic [7:0] m_sc, m_ec;
    logic [3:0] m_cov;
    logic [2:0] m_ev;

    always_comb begin
        m_valid = use_sat ? valid_s : in_valid;
        m_ready = use_sat ? rdy_s : in_ready;
        m_sc    = use_sat ? {6'b0, sc_s} : sample_cnt;
        m_ec    = use_sat ? {6'b0, ec_s} : err_cnt;
        m_cov   = use_sat ? cov_s : cov_mask;
        m_ev    = use_sat ? ev_s : err_vec;
        m_err   = use_sat ? error_s : error;
        m_dn    = use_sat ? done_s : done;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    endtask

    function automatic exp_t mk(input logic [7:0] sc, input logic [7:0] ec,
                                input logic [3:0] cov, input logic [2:0] ev,
                                input logic err, input logic dn, input logic rdy);
        exp_t e;
        e.sc = sc; e.ec = ec; e.cov = cov; e.ev = ev;
        e.err = err; e.dn = dn; e.rdy = rdy;
        return e;
    endfunction

    // Monitor: a transfer seen at one negedge is checked on the next edge and
    // its results compared two negedges later, unless clear/reset intervened.
    logic st1 = 1'b0;
    logic st2 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (st2) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_result", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sample_cnt", {24'b0, m_sc}, {24'b0, e.sc});
                chk("err_cnt", {24'b0, m_ec}, {24'b0, e.ec});
                chk("cov_mask", {28'b0, m_cov}, {28'b0, e.cov});
                chk("err_vec", {29'b0, m_ev}, {29'b0, e.ev});
                chk("error", {31'b0, m_err}, {31'b0, e.err});
                chk("done", {31'b0, m_dn}, {31'b0, e.dn});
                chk("in_ready", {31'b0, m_ready}, {31'b0, e.rdy});
            end
        end
        st2 = st1 && rst_n && !clear;
        st1 = rst_n && m_valid && m_ready && !clear;
    end

    // Issue one sample; returns #1 after the transfer edge.
    task automatic send(input logic ia, input logic ib, input logic ya,
                        input logic yo, input logic yn, input logic push,
                        input logic hold, input exp_t e);
        bit ok;
        a = ia; b = ib; y_and = ya; y_or = yo; y_not = yn;
        if (use_sat) valid_s = 1'b1; else in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0; valid_s = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (push) q.push_back(e);
        if (!hold) begin
            in_valid = 1'b0; valid_s = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        // Reset state, asserted from time zero.
        #1;
        chk("rst_sample_cnt", {24'b0, sample_cnt}, 0);
        chk("rst_cov_mask", {28'b0, cov_mask}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_done", {31'b0, done}, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Clean sweep with in_valid held: transfers every 2nd cycle.
        send(0, 0, 0, 0, 1, 1, 1, mk(1, 0, 4'b0001, 3'b000, 0, 0, 1));
        prev = cyc;
        send(0, 1, 0, 1, 1, 1, 1, mk(2, 0, 4'b0011, 3'b000, 0, 0, 1));
        chk("xfer_spacing_1", cyc - prev, 2); prev = cyc;
        send(1, 0, 0, 1, 0, 1, 1, mk(3, 0, 4'b0111, 3'b000, 0, 0, 1));
        chk("xfer_spacing_2", cyc - prev, 2); prev = cyc;
        send(1, 1, 1, 1, 0, 1, 1, mk(4, 0, 4'b1111, 3'b000, 0, 1, 0));
        chk("xfer_spacing_3", cyc - prev, 2);
        // DONE: valid still held, nothing accepted.
        repeat (6) @(posedge clk);
        #1;
        chk("done_hold_sample_cnt", {24'b0, sample_cnt}, 4);
        chk("done_in_ready", {31'b0, in_ready}, 0);
        chk("done_flag", {31'b0, done}, 1);
        in_valid = 1'b0;
        pulse_clear();
        chk("clr_sample_cnt", {24'b0, sample_cnt}, 0);
        chk("clr_done", {31'b0, done}, 0);
        chk("clr_in_ready", {31'b0, in_ready}, 1);

        // Faulty AND, then a correct sample: error and err_vec hold.
        send(1, 1, 0, 1, 0, 1, 0, mk(1, 1, 4'b1000, 3'b100, 1, 0, 1));
        send(0, 0, 0, 0, 1, 1, 0, mk(2, 1, 4'b1001, 3'b100, 1, 0, 1));
        repeat (2) @(posedge clk);

        // Clear together with a transfer: clear wins, sample dropped.
        #1;
        a = 0; b = 1; y_and = 0; y_or = 1; y_not = 1;
        in_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
        chk("clrx_sample_cnt", {24'b0, sample_cnt}, 0);
        chk("clrx_err_cnt", {24'b0, err_cnt}, 0);
        chk("clrx_err_vec", {29'b0, err_vec}, 0);
        chk("clrx_error", {31'b0, error}, 0);
        chk("clrx_cov_mask", {28'b0, cov_mask}, 0);
        chk("clrx_in_ready", {31'b0, in_ready}, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("clrx_dropped", {24'b0, sample_cnt}, 0);

        // Clear during CHECK discards the in-flight sample.
        send(0, 1, 0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clrc_in_ready", {31'b0, in_ready}, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("clrc_sample_cnt", {24'b0, sample_cnt}, 0);
        chk("clrc_cov_mask", {28'b0, cov_mask}, 0);

        // Async reset mid-CHECK after a failing sample.
        send(0, 0, 0, 0, 0, 1, 0, mk(1, 1, 4'b0001, 3'b001, 1, 0, 1));
        send(1, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sample_cnt", {24'b0, sample_cnt}, 0);
        chk("arst_err_cnt", {24'b0, err_cnt}, 0);
        chk("arst_err_vec", {29'b0, err_vec}, 0);
        chk("arst_error", {31'b0, error}, 0);
        chk("arst_cov_mask", {28'b0, cov_mask}, 0);
        chk("arst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        send(0, 1, 0, 1, 1, 1, 0, mk(1, 0, 4'b0010, 3'b000, 0, 0, 1));
        repeat (3) @(posedge clk);

        // Saturation on the 2-bit instance: five failing 00 samples.
        pulse_clear();
        use_sat = 1'b1;
        send(0, 0, 1, 0, 1, 1, 0, mk(1, 1, 4'b0001, 3'b100, 1, 0, 1));
        send(0, 0, 1, 0, 1, 1, 0, mk(2, 2, 4'b0001, 3'b100, 1, 0, 1));
        send(0, 0, 1, 0, 1, 1, 0, mk(3, 3, 4'b0001, 3'b100, 1, 0, 1));
        send(0, 0, 1, 0, 1, 1, 0, mk(3, 3, 4'b0001, 3'b100, 1, 0, 1));
        send(0, 0, 1, 0, 1, 1, 0, mk(3, 3, 4'b0001, 3'b100, 1, 0, 1));
        repeat (4) @(posedge clk);
        #1;
        chk("sat_done", {31'b0, done_s}, 0);
        chk("sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the sample and error counters.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port clear, input, 1, synchronous clear of all checker state.
REQ-005 The block SHALL have port in_valid, input, 1, stimulus/response sample present.
REQ-006 The block SHALL have port in_ready, output, 1, checker can accept a sample.
REQ-007 The block SHALL have ports a and b, input, 1 each, the gate stimulus applied.
REQ-008 The block SHALL have ports y_and, y_or and y_not, input, 1 each, the observed gate responses.
REQ-009 The block SHALL have port sample_cnt, output, CNT_W, number of samples checked.
REQ-010 The block SHALL have port err_cnt, output, CNT_W, number of samples with at least one mismatch.
REQ-011 The block SHALL have port cov_mask, output, 4, where bit {a,b} is set once that input combination has been checked.
REQ-012 The block SHALL have port err_vec, output, 3, {and,or,not} mismatch flags of the most recent failing sample.
REQ-013 The block SHALL have port error, output, 1, sticky flag set by any mismatch.
REQ-014 The block SHALL have port done, output, 1, asserted when all four combinations have been covered.

Function
REQ-015 The block SHALL transfer a sample on a rising edge when in_valid and in_ready are both 1, registering a, b, y_and, y_or and y_not.
REQ-016 The state machine SHALL have the states IDLE, CHECK and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in CHECK and DONE, in_ready SHALL be 0.
REQ-018 The transition IDLE->CHECK SHALL occur on a transfer; CHECK SHALL last exactly one cycle.
REQ-019 In CHECK, the block SHALL compute expected values y_and=a&b, y_or=a|b, y_not=~a from the registered sample and compare them with the registered responses.
REQ-020 On the CHECK->next edge, sample_cnt SHALL increment and cov_mask[{a,b}] SHALL be set.
REQ-021 On the same CHECK->next edge, if any mismatch exists: err_cnt SHALL increment, err_vec SHALL load the mismatch flags and error SHALL be set.
REQ-022 Results SHALL be visible 2 cycles after the transfer edge; throughput SHALL be at most 1 sample per 2 cycles.
REQ-023 CHECK SHALL go to DONE if the updated cov_mask equals 4'b1111, otherwise to IDLE.
REQ-024 DONE SHALL hold all outputs, set done=1, and accept no samples until clear.
REQ-025 sample_cnt and err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Repeated samples of an already covered combination SHALL be counted and checked, and SHALL NOT change cov_mask.
REQ-027 err_vec SHALL hold its value on passing samples.
REQ-028 error SHALL clear only on clear or reset.
REQ-029 clear SHALL return the block to IDLE and zero all counters, cov_mask, err_vec, error and done on the next edge.
REQ-030 clear SHALL have priority over a simultaneous transfer, which is dropped.
REQ-031 clear asserted during CHECK SHALL discard the in-flight sample without updating counters.
REQ-032 in_valid SHALL be ignored while in_ready=0; inputs are don't-care when no transfer occurs.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately force IDLE, sample_cnt=0, err_cnt=0, cov_mask=0, err_vec=0, error=0 and done=0, independent of clk.
REQ-034 in_ready SHALL be 1 while in reset, since the state is IDLE.
REQ-035 Reset asserted mid-CHECK SHALL discard the in-flight sample.
REQ-036 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-037 Clean sweep: the bench SHALL apply (a,b)=00,01,10,11 with correct responses -> sample_cnt=4, err_cnt=0, cov_mask=1111, done=1, error=0, in_ready=0.
REQ-038 Faulty AND: the bench SHALL apply a=1, b=1, y_and=0, y_or=1, y_not=0 -> err_cnt=1, err_vec=100, error=1, cov_mask=1000.
REQ-039 Sticky and hold: after REQ-038, the bench SHALL apply correct 00 -> error stays 1, err_vec stays 100, sample_cnt=2.
REQ-040 Handshake: the bench SHALL hold in_valid=1 continuously -> transfers occur every 2nd cycle, and none occur in DONE.
REQ-041 Clear priority: the bench SHALL assert clear together with a transfer, and separately during CHECK -> all counters 0 next cycle, state IDLE, sample not counted.
REQ-042 Async reset: the bench SHALL drop rst_n between clock edges mid-CHECK -> outputs zero immediately, in_ready=1.
REQ-043 Saturation: with CNT_W=2, the bench SHALL apply 5 failing samples on combination 00 -> sample_cnt=3, err_cnt=3, done=0.
